// File: rtl/fmul32_norm_round.sv
// fmul32_norm_round: normalize, round-to-nearest-even and pack stage of the
// binary32 multiplier. Two registered stages behind a valid/ready handshake:
// stage 1 normalizes and applies the denormal right shift, stage 2 rounds,
// packs and raises the exception flags.
module fmul32_norm_round (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_in,
    input  logic [47:0]        mant_prod,
    input  logic signed [9:0]  exp_res_tmp,
    input  logic [7:0]         denorm_shift,
    input  logic               prev_inf,
    input  logic               prev_overflow,
    input  logic               nan_in,
    input  logic               inf_in,
    input  logic               zero_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        result,
    output logic               flag_overflow,
    output logic               flag_underflow,
    output logic               flag_inexact
);

    // Special-operand result word: {hit, result[31:0], overflow, underflow, inexact}.
    function automatic logic [35:0] f_special(
        input logic sign,
        input logic nan,
        input logic inf,
        input logic zero,
        input logic huge
    );
        logic [35:0] r;
        r = '0;
        if (nan) begin
            r = {1'b1, 32'h7FC0_0000, 3'b000};
        end else if (inf) begin
            r = {1'b1, sign, 8'hFF, 23'd0, 3'b000};
        end else if (zero) begin
            r = {1'b1, sign, 31'd0, 3'b000};
        end else if (huge) begin
            r = {1'b1, sign, 8'hFF, 23'd0, 3'b101};
        end
        return r;
    endfunction

    // Round to nearest even and pack: returns {result[31:0], overflow, underflow, inexact}.
    function automatic logic [34:0] f_round_pack(
        input logic               sign,
        input logic signed [9:0]  ee,
        input logic [47:0]        w,
        input logic               sticky_s,
        input logic               denorm
    );
        logic [23:0]       m;
        logic              guard;
        logic              sticky;
        logic              inc;
        logic              inexact;
        logic [24:0]       m_r;
        logic [22:0]       frac;
        logic signed [9:0] ee_r;
        logic [34:0]       r;
        m       = w[47:24];
        guard   = w[23];
        sticky  = (|w[22:0]) | sticky_s;
        inc     = guard & (sticky | m[0]);
        inexact = guard | sticky;
        m_r     = {1'b0, m} + {24'd0, inc};
        frac    = m_r[22:0];
        ee_r    = ee;
        if (denorm) begin
            // m_r[23] lands in the exponent field: rounding into the hidden bit gives exponent 1.
            r = {sign, 7'd0, m_r[23:0], 1'b0, inexact, inexact};
        end else begin
            if (m_r[24]) begin
                frac = m_r[23:1];
                ee_r = ee + 10'sd1;
            end
            if (ee_r >= 10'sd255) begin
                r = {sign, 8'hFF, 23'd0, 3'b101};
            end else begin
                r = {sign, ee_r[7:0], frac, 2'b00, inexact};
            end
        end
        return r;
    endfunction

    logic              w_s2_load;
    logic              w_s1_load;
    logic              w_top;
    logic [47:0]       w_norm_s1;
    logic signed [9:0] w_ee_s1;
    logic              w_denorm_s1;
    logic [8:0]        w_shamt_s1;
    logic [47:0]       w_mask_s1;
    logic [47:0]       w_shifted_s1;
    logic              w_sticky_s1;
    logic [35:0]       w_spec_s1;
    logic [34:0]       w_pack_s2;

    logic              r_vld_p1;
    logic              r_sign_p1;
    logic signed [9:0] r_ee_p1;
    logic [47:0]       r_w_p1;
    logic              r_sticky_p1;
    logic              r_denorm_p1;
    logic              r_spec_p1;
    logic [34:0]       r_spec_word_p1;

    logic              r_vld_p2;
    logic [31:0]       r_res_p2;
    logic              r_ovf_p2;
    logic              r_unf_p2;
    logic              r_inx_p2;

    // Handshake: a stage advances when its downstream slot is free or draining.
    always_comb begin
        w_s2_load = !r_vld_p2 | out_ready;
        w_s1_load = !r_vld_p1 | w_s2_load;
        in_ready  = w_s1_load & !rst;
    end

    // Stage 1 datapath: normalize the product and apply the denormal right shift.
    always_comb begin
        w_top        = mant_prod[47];
        w_norm_s1    = w_top ? mant_prod : {mant_prod[46:0], 1'b0};
        w_ee_s1      = exp_res_tmp + (w_top ? 10'sd1 : 10'sd0);
        w_denorm_s1  = exp_res_tmp[9] | (exp_res_tmp == 10'sd0);
        w_shamt_s1   = w_denorm_s1 ? ({1'b0, denorm_shift} + {8'd0, ~w_top}) : 9'd0;
        w_mask_s1    = '0;
        w_shifted_s1 = '0;
        w_sticky_s1  = 1'b0;
        if (w_shamt_s1 >= 9'd48) begin
            w_sticky_s1 = |w_norm_s1;
        end else begin
            w_mask_s1    = ~({48{1'b1}} << w_shamt_s1[5:0]);
            w_shifted_s1 = w_norm_s1 >> w_shamt_s1[5:0];
            w_sticky_s1  = |(w_norm_s1 & w_mask_s1);
        end
        w_spec_s1 = f_special(sign_in, nan_in, inf_in, zero_in, prev_inf | prev_overflow);
    end

    // ---- stage 1 boundary: normalized/shifted significand ----
    // Stage 1 valid bit; in-flight beats are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_load) begin
            r_vld_p1 <= in_valid;
        end
    end

    // Stage 1 payload, captured only when a beat is actually accepted.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            r_sign_p1      <= sign_in;
            r_ee_p1        <= w_ee_s1;
            r_w_p1         <= w_shifted_s1;
            r_sticky_p1    <= w_sticky_s1;
            r_denorm_p1    <= (w_shamt_s1 != 9'd0);
            r_spec_p1      <= w_spec_s1[35];
            r_spec_word_p1 <= w_spec_s1[34:0];
        end
    end

    // Stage 2 datapath: round and pack unless a special result was decided up front.
    always_comb begin
        w_pack_s2 = r_spec_p1 ? r_spec_word_p1
                              : f_round_pack(r_sign_p1, r_ee_p1, r_w_p1, r_sticky_p1, r_denorm_p1);
    end

    // ---- stage 2 boundary: packed result and flags ----
    // Output register; holds while the consumer stalls, clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
            r_res_p2 <= '0;
            r_ovf_p2 <= 1'b0;
            r_unf_p2 <= 1'b0;
            r_inx_p2 <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_res_p2 <= w_pack_s2[34:3];
                r_ovf_p2 <= w_pack_s2[2];
                r_unf_p2 <= w_pack_s2[1];
                r_inx_p2 <= w_pack_s2[0];
            end
        end
    end

    assign out_valid      = r_vld_p2;
    assign result         = r_res_p2;
    assign flag_overflow  = r_ovf_p2;
    assign flag_underflow = r_unf_p2;
    assign flag_inexact   = r_inx_p2;

endmodule

// File: tb/tb_fmul32_norm_round.sv
// Testbench for fmul32_norm_round: directed vectors, randomized traffic
// against a value-level rounding model, backpressure and reset behaviour.
module tb_fmul32_norm_round;

    typedef struct {
        bit        sign;
        bit [47:0] mant;
        bit [9:0]  exp;
        bit [7:0]  dsh;
        bit        pinf;
        bit        povf;
        bit        nan;
        bit        inf;
        bit        zero;
    } beat_t;

    typedef struct {
        bit [31:0] res;
        bit        ovf;
        bit        unf;
        bit        inx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [47:0] mant_prod = '0;
    logic [9:0]  exp_res_tmp = '0;
    logic [7:0]  denorm_shift = '0;
    logic        prev_inf = 1'b0;
    logic        prev_overflow = 1'b0;
    logic        nan_in = 1'b0;
    logic        inf_in = 1'b0;
    logic        zero_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fmul32_norm_round dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .mant_prod(mant_prod),
        .exp_res_tmp(exp_res_tmp), .denorm_shift(denorm_shift),
        .prev_inf(prev_inf), .prev_overflow(prev_overflow),
        .nan_in(nan_in), .inf_in(inf_in), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(bit s, bit [47:0] m, bit [9:0] e);
        beat_t b;
        int    ei;
        ei     = int'($signed(e));
        b.sign = s;
        b.mant = m;
        b.exp  = e;
        b.dsh  = (ei < 0) ? 8'(-ei) : 8'd0;
        b.pinf = (ei == 255);
        b.povf = (e[9:8] == 2'b01);
        b.nan  = 1'b0;
        b.inf  = 1'b0;
        b.zero = 1'b0;
        return b;
    endfunction

    // Value-level reference: the exact value is mant * 2^(e-173); quantize it
    // to the binary32 grid (ulp 2^(eb-150) for normals, 2^-149 for denormals).
    function automatic exp_t model(beat_t b);
        exp_t   r;
        longint p, q, rem, half;
        int     e, eb, k;
        bit     inexact;
        r.res = '0; r.ovf = 1'b0; r.unf = 1'b0; r.inx = 1'b0;
        if (b.nan) begin
            r.res = 32'h7FC0_0000;
        end else if (b.inf) begin
            r.res = {b.sign, 8'hFF, 23'd0};
        end else if (b.zero) begin
            r.res = {b.sign, 31'd0};
        end else if (b.pinf || b.povf) begin
            r.res = {b.sign, 8'hFF, 23'd0}; r.ovf = 1'b1; r.inx = 1'b1;
        end else begin
            p  = longint'({16'd0, b.mant});
            e  = int'($signed(b.exp));
            eb = e + int'(b.mant[47]);
            k  = (eb >= 1) ? 23 + int'(b.mant[47]) : 24 - e;
            if (k >= 50) begin
                q   = 0;
                rem = p;
            end else begin
                q    = p >> k;
                rem  = p - (q << k);
                half = longint'(1) << (k - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
            end
            inexact = (rem != 0);
            if (eb >= 1) begin
                if (q == (longint'(1) << 24)) begin
                    q  = q >> 1;
                    eb = eb + 1;
                end
                if (eb >= 255) begin
                    r.res = {b.sign, 8'hFF, 23'd0}; r.ovf = 1'b1; r.inx = 1'b1;
                end else begin
                    r.res = {b.sign, 8'(eb), 23'(q)}; r.inx = inexact;
                end
            end else begin
                r.res = {b.sign, 31'(q)}; r.inx = inexact; r.unf = inexact;
            end
        end
        return r;
    endfunction

    function automatic beat_t rnd_beat(bit allow_special);
        bit [23:0] a, c;
        int        e, sel;
        beat_t     b;
        a = 24'($urandom) | 24'h80_0000;
        c = 24'($urandom) | 24'h80_0000;
        if ($urandom_range(0, 9) < 4) e = int'($urandom_range(0, 34)) - 30;
        else                          e = int'($urandom_range(0, 520)) - 200;
        b = mk(1'($urandom), 48'(a) * 48'(c), 10'(e));
        if (allow_special) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) b.nan  = 1'b1;
            if (sel == 1) b.inf  = 1'b1;
            if (sel == 2) b.zero = 1'b1;
        end
        return b;
    endfunction

    task automatic drive(input beat_t b);
        sign_in       = b.sign;
        mant_prod     = b.mant;
        exp_res_tmp   = b.exp;
        denorm_shift  = b.dsh;
        prev_inf      = b.pinf;
        prev_overflow = b.povf;
        nan_in        = b.nan;
        inf_in        = b.inf;
        zero_in       = b.zero;
    endtask

    // Sends one beat into an idle pipeline and returns the emerging result;
    // lat counts rising edges from the accepting edge up to out_valid.
    task automatic run_beat(input beat_t b, output exp_t got, output int lat);
        int w;
        drive(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        lat = 1;
        in_valid = 1'b0;
        #1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
            #1;
        end
        got.res = result;
        got.ovf = flag_overflow;
        got.unf = flag_underflow;
        got.inx = flag_inexact;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(mk(1'b0, 48'h9000_0000_0000, 10'd127));
        repeat (3) tick();
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", result); else n_pass++;
        n_total++;
        if ({flag_overflow, flag_underflow, flag_inexact} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {flag_overflow, flag_underflow, flag_inexact});
        else n_pass++;
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_directed();
        beat_t     vb[12];
        bit [31:0] eres[12];
        bit [2:0]  eflg[12];
        exp_t      got;
        int        lat;
        vb[0]  = mk(1'b0, 48'h9000_0000_0000, 10'd127);  eres[0]  = 32'h4010_0000; eflg[0]  = 3'b000;
        vb[1]  = mk(1'b0, 48'h8000_0180_0000, 10'd126);  eres[1]  = 32'h3F80_0002; eflg[1]  = 3'b001;
        vb[2]  = mk(1'b0, 48'h8000_0080_0000, 10'd126);  eres[2]  = 32'h3F80_0000; eflg[2]  = 3'b001;
        vb[3]  = mk(1'b0, 48'h7FFF_FFC0_0000, 10'd254);  eres[3]  = 32'h7F80_0000; eflg[3]  = 3'b101;
        vb[4]  = mk(1'b1, 48'h9000_0000_0000, 10'h100);  eres[4]  = 32'hFF80_0000; eflg[4]  = 3'b101;
        vb[5]  = mk(1'b0, 48'h4000_0000_0000, 10'h3FF);  eres[5]  = 32'h0020_0000; eflg[5]  = 3'b000;
        vb[6]  = mk(1'b0, 48'h9000_0000_0000, 10'h381);  eres[6]  = 32'h0000_0000; eflg[6]  = 3'b011;
        vb[7]  = mk(1'b0, 48'h9000_0000_0000, 10'h100);  eres[7]  = 32'h7FC0_0000; eflg[7]  = 3'b000;
        vb[7].nan = 1'b1;
        vb[8]  = mk(1'b1, 48'h9000_0000_0000, 10'd100);  eres[8]  = 32'hFF80_0000; eflg[8]  = 3'b000;
        vb[8].inf = 1'b1;
        vb[9]  = mk(1'b1, 48'h9000_0000_0000, 10'd255);  eres[9]  = 32'h8000_0000; eflg[9]  = 3'b000;
        vb[9].zero = 1'b1;
        vb[10] = mk(1'b0, 48'h9000_0000_0000, 10'd0);    eres[10] = 32'h0090_0000; eflg[10] = 3'b000;
        vb[11] = mk(1'b0, 48'h7FFF_FFC0_0000, 10'd0);    eres[11] = 32'h0080_0000; eflg[11] = 3'b011;
        for (int i = 0; i < 12; i++) begin
            run_beat(vb[i], got, lat);
            n_total++;
            if (lat != 2) $display("FAIL dir%0d_latency: got %0d edges expected 2", i, lat); else n_pass++;
            n_total++;
            if (got.res !== eres[i]) $display("FAIL dir%0d_result: got %h expected %h", i, got.res, eres[i]); else n_pass++;
            n_total++;
            if ({got.ovf, got.unf, got.inx} !== eflg[i])
                $display("FAIL dir%0d_flags(ovf,unf,inx): got %b expected %b", i, {got.ovf, got.unf, got.inx}, eflg[i]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_random();
        exp_t  q[$];
        exp_t  e;
        beat_t cur;
        cur = rnd_beat(1'b1);
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            drive(cur);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL rnd_extra_beat: got %h expected no output", result);
                end else begin
                    e = q.pop_front();
                    n_total++;
                    if (result !== e.res) $display("FAIL rnd_result: got %h expected %h", result, e.res); else n_pass++;
                    n_total++;
                    if ({flag_overflow, flag_underflow, flag_inexact} !== {e.ovf, e.unf, e.inx})
                        $display("FAIL rnd_flags: got %b expected %b", {flag_overflow, flag_underflow, flag_inexact}, {e.ovf, e.unf, e.inx});
                    else n_pass++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cur));
                cur = rnd_beat(1'b1);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid && q.size() > 0) begin
                e = q.pop_front();
                n_total++;
                if (result !== e.res) $display("FAIL rnd_drain_result: got %h expected %h", result, e.res); else n_pass++;
            end
            tick();
        end
        n_total++;
        if (q.size() != 0) $display("FAIL rnd_lost_beats: got %0d missing expected 0", q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        beat_t     bq[4];
        exp_t      exq[$];
        exp_t      e;
        int        idx, got, first, last;
        bit        seen;
        bit [31:0] held;
        for (int i = 0; i < 4; i++) bq[i] = rnd_beat(1'b0);
        idx = 0; seen = 1'b0; held = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            drive(bq[idx < 4 ? idx : 3]);
            #1;
            if (seen) begin
                n_total++;
                if ({out_valid, result} !== {1'b1, held})
                    $display("FAIL bp_hold: got %b/%h expected 1/%h", out_valid, result, held);
                else n_pass++;
            end else if (out_valid) begin
                seen = 1'b1;
                held = result;
            end
            if (in_valid && in_ready) begin
                exq.push_back(model(bq[idx]));
                idx++;
            end
            tick();
        end
        #1;
        n_total++; if (idx != 2) $display("FAIL bp_accepted: got %0d expected 2", idx); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else n_pass++;
        out_ready = 1'b1;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            in_valid = (idx < 4);
            drive(bq[idx < 4 ? idx : 3]);
            #1;
            if (out_valid && exq.size() > 0) begin
                e = exq.pop_front();
                n_total++;
                if (result !== e.res) $display("FAIL bp_order%0d: got %h expected %h", got, result, e.res); else n_pass++;
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (in_valid && in_ready) begin
                exq.push_back(model(bq[idx]));
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_total++; if (got != 4) $display("FAIL bp_count: got %0d expected 4", got); else n_pass++;
        n_total++; if (last - first != 3) $display("FAIL bp_rate: got span %0d expected 3", last - first); else n_pass++;
    endtask

    task automatic test_reset_inflight();
        exp_t got;
        int   lat, stale;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            drive(rnd_beat(1'b0));
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL inflight_full: got %b expected 1", out_valid); else n_pass++;
        rst = 1'b1;
        tick();
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_flush_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL rst_flush_result: got %h expected 00000000", result); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_flush_in_ready: got %b expected 0", in_ready); else n_pass++;
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) stale++;
            tick();
        end
        n_total++; if (stale != 0) $display("FAIL rst_stale_beats: got %0d expected 0", stale); else n_pass++;
        run_beat(mk(1'b0, 48'h9000_0000_0000, 10'd127), got, lat);
        n_total++; if (lat != 2) $display("FAIL post_rst_latency: got %0d expected 2", lat); else n_pass++;
        n_total++; if (got.res !== 32'h4010_0000) $display("FAIL post_rst_result: got %h expected 40100000", got.res); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fmul32_norm_round.md
# fmul32_norm_round

Normalization, rounding and packing stage of the FMUL32 datapath. It sits directly downstream of the exponent-sum analyzer and consumes its outputs: the tentative exponent, the denormal shift amount and the inf/overflow hints. It also takes the raw 48-bit mantissa product and the special-operand flags. It produces the packed IEEE-754 single-precision result with exception flags through a 2-stage valid/ready pipeline.

## Interface
Parameters:
- none (format fixed to binary32; round-to-nearest-even only)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- sign_in  in  1  result sign (signA ^ signB)
- mant_prod  in  48  product of two 24-bit mantissas with hidden bits; value = mant_prod × 2^-46
- exp_res_tmp  in  10  biased exponent expA+expB-127, two's complement
- denorm_shift  in  8  analyzer shift: -exp_res_tmp when exp_res_tmp<0, else 0
- prev_inf  in  1  exp_res_tmp == 255
- prev_overflow  in  1  exp_res_tmp[9:8] == 01
- nan_in / inf_in / zero_in  in  1 each  special-operand class from classifier (inf×0 arrives as nan_in)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  32  packed float
- flag_overflow / flag_underflow / flag_inexact  out  1 each  IEEE exception flags for this result

## Operation
- Special priority: nan_in → 0x7FC00000, no flags. Next inf_in → {sign,0xFF,0}, no flags. Next zero_in → {sign,31'b0}, no flags. Next prev_inf|prev_overflow → {sign,0xFF,0}, overflow=1, inexact=1. Otherwise normal path.
- Stage 1, normalize and shift:
  - If mant_prod[47], then w=mant_prod and ee=exp_res_tmp+1.
  - Else w=mant_prod<<1 and ee=exp_res_tmp. All exponent arithmetic is 10-bit signed.
  - Denormal when exp_res_tmp[9] or exp_res_tmp==0. Right-shift amount = denorm_shift + !mant_prod[47], computed 9 bits wide, otherwise 0. A shift of 0 means normal.
  - Shift ≥ 48 moves all of w into sticky. Shifted-out bits OR into sticky_s.
- Stage 2, round and pack:
  - m = w[47:24] (24 bits), guard = w[23], sticky = |w[22:0] | sticky_s.
  - Increment m when guard & (sticky | m[0]). inexact = guard | sticky.
  - Normal path: a carry to bit 24 gives m>>1, ee+1. If ee ≥ 255 after rounding → ±inf, overflow=1, inexact=1. Else result = {sign, ee[7:0], m[22:0]}.
  - Denormal path: exponent field = m[23] (rounding into the hidden bit yields exponent 1). underflow = inexact. An all-zero m gives signed zero.
- Flags are zero whenever not stated.

## Timing
- Latency 2: a beat accepted at edge k is presented with out_valid=1 from edge k+2. Throughput 1 beat/cycle.
- Stage-advance rules:
  - s2 loads when !s2_valid | out_ready.
  - s1 loads when !s1_valid | s2 loads.
  - in_ready = (!s1_valid | s2 loads) & !rst. This is a combinational path from out_ready and is permitted.
- Bubbles collapse. Beats stay in order with no drop or duplication.
- While out_valid & !out_ready: result and flags hold stable.
- Transfer occurs only on in_valid&in_ready or out_valid&out_ready at a rising edge. Input values are ignored otherwise.
- Reset, from the edge where rst is sampled high:
  - s1_valid=0, s2_valid=0, out_valid=0, result=0, all flags=0, in_ready=0 while rst high.
  - In-flight beats are discarded.
  - The first accept is possible in the first cycle after rst deasserts.

## Test plan
- Feed 1.5×1.5: mant_prod=0x900000000000, exp_res_tmp=127, sign 0 → result 0x40100000 two cycles later, no flags.
- Feed the tie case mant_prod=0x800001800000, exp 126 → 0x3F800002 with inexact. Then feed mant_prod=0x800000800000 → 0x3F800000 (ties to even), inexact=1.
- Feed exp_res_tmp=254, mant_prod=0x7FFFFFC00000, sign 0 → rounding carry gives 0x7F800000, overflow=1, inexact=1. Separately, prev_overflow=1 with sign 1 → 0xFF800000.
- Feed exp_res_tmp=0x3FF, denorm_shift=1, mant_prod=0x400000000000 → 0x00200000, underflow=0 (exact). Then feed exp_res_tmp=0x381, denorm_shift=127 → 0x00000000, underflow=1, inexact=1.
- Backpressure: send 4 beats back-to-back with out_ready=0 → in_ready drops after 2 accepted, result stays stable. Raise out_ready → all 4 results emerge in order, one per cycle.
- Specials and reset:
  - nan_in together with prev_overflow → 0x7FC00000, no flags.
  - Assert rst with 2 beats in flight → out_valid=0, result=0 at the next edge, and no stale beat after release.
